rib_arbiter: RTL and testbench



---
 rtl/rib_arbiter_if.sv | 42 ++++
 rtl/rib_arbiter.sv | 148 ++++++++++++++
 tb/tb_rib_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rib_arbiter_if.sv
// RIB arbiter bus bundle: request/ack in, grant/status out.
// Latency: n/a (wires only).
// Backpressure: n/a; ownership is held by the arbiter until ack, drop or timeout.
//
// Signals:
//   req_i        [2:0] per-master request, bit n = master n
//   ack_i              ack from the slave addressed by the granted master
//   grant_o      [2:0] one-hot registered grant, zero when idle
//   busy_o             registered, high while a transaction is outstanding
//   hold_flag_o        combinational core pipeline hold
//   err_o              registered one-cycle timeout pulse
//   err_master_o [1:0] master index of the last timeout
// Modports: master = requester side, slave = arbiter side.
interface rib_arbiter_if;
  logic [2:0] req_i;
  logic       ack_i;
  logic [2:0] grant_o;
  logic       busy_o;
  logic       hold_flag_o;
  logic       err_o;
  logic [1:0] err_master_o;

  modport master (
    output req_i,
    output ack_i,
    input  grant_o,
    input  busy_o,
    input  hold_flag_o,
    input  err_o,
    input  err_master_o
  );

  modport slave (
    input  req_i,
    input  ack_i,
    output grant_o,
    output busy_o,
    output hold_flag_o,
    output err_o,
    output err_master_o
  );
endinterface

// File: rtl/rib_arbiter.sv
// RIB bus arbiter: picks one of m0 (load/store), m1 (fetch), m2 (debug), holds grant until ack.
// Latency: request to grant 1 cycle from idle; ack to next grant 1 cycle, no bubble.
// Backpressure: grant held while ack low and req held; starvation counters force progress.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - rib_arbiter_if.slave (req_i/ack_i in; grant_o/busy_o/hold_flag_o/err_o/err_master_o out)
// Optional feature macro: RIB_ARB_TIMEOUT_EN enables the ack wait timeout and err_o reporting;
// without it err_o and err_master_o are tied low and BUSY waits forever.
module rib_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  rib_arbiter_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  state_t     r_state;
  logic [2:0] r_grant;
  logic       r_busy;
  logic [3:0] r_cnt [3];

  logic [2:0] w_req;
  logic [2:0] w_starved;
  logic [2:0] w_win;
  logic       w_arb_edge;
  logic       w_owner_req;

`ifdef RIB_ARB_TIMEOUT_EN
  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_wait;
  logic        r_err;
  logic [1:0]  r_err_master;
  logic [1:0]  w_grant_idx;

  assign w_grant_idx = r_grant[2] ? 2'd2 : (r_grant[1] ? 2'd1 : 2'd0);
`endif

  // Winner selection: a starved requester beats everything (lowest index first),
  // otherwise fixed priority m2 > m0 > m1.
  always_comb begin
    w_req = bus.req_i;
    for (int i = 0; i < 3; i++) begin
      w_starved[i] = w_req[i] && (r_cnt[i] == LP_LIMIT);
    end
    w_win = 3'b000;
    if (w_starved[0])      w_win = 3'b001;
    else if (w_starved[1]) w_win = 3'b010;
    else if (w_starved[2]) w_win = 3'b100;
    else if (w_req[2])     w_win = 3'b100;
    else if (w_req[0])     w_win = 3'b001;
    else if (w_req[1])     w_win = 3'b010;
  end

  // Arbitration happens on an idle edge with a request, or on the ack edge that
  // completes a transaction (ack wins over a simultaneous req drop).
  assign w_arb_edge  = (r_state == ST_IDLE) ? (|w_req) : bus.ack_i;
  assign w_owner_req = |(r_grant & w_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= 3'b000;
      r_busy  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= 4'd0;
      end
`ifdef RIB_ARB_TIMEOUT_EN
      r_wait       <= 16'd0;
      r_err        <= 1'b0;
      r_err_master <= 2'd0;
`endif
    end else begin
`ifdef RIB_ARB_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      if (w_arb_edge) begin
        r_grant <= w_win;
        r_busy  <= |w_req;
        r_state <= (|w_req) ? ST_BUSY : ST_IDLE;
        // Losers that keep requesting age towards the limit; everyone else resets.
        for (int i = 0; i < 3; i++) begin
          if (w_win[i] || !w_req[i]) begin
            r_cnt[i] <= 4'd0;
          end else if (r_cnt[i] != LP_LIMIT) begin
            r_cnt[i] <= r_cnt[i] + 4'd1;
          end
        end
`ifdef RIB_ARB_TIMEOUT_EN
        r_wait <= 16'd0;
`endif
      end else if (r_state == ST_BUSY) begin
        if (!w_owner_req) begin
          // Owner gave up without ack: release the bus, counters untouched.
          r_grant <= 3'b000;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
`ifdef RIB_ARB_TIMEOUT_EN
        else if (r_wait == LP_TIMEOUT) begin
          r_err        <= 1'b1;
          r_err_master <= w_grant_idx;
          r_grant      <= 3'b000;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
          for (int i = 0; i < 3; i++) begin
            if (r_grant[i]) begin
              r_cnt[i] <= 4'd0;
            end
          end
        end else begin
          r_wait <= r_wait + 16'd1;
        end
`endif
      end
    end
  end

  assign bus.grant_o     = r_grant;
  assign bus.busy_o      = r_busy;
  // Fetch stalls whenever execute or debug wants or owns the bus.
  assign bus.hold_flag_o = w_req[0] | w_req[2] | r_grant[0] | r_grant[2];

`ifdef RIB_ARB_TIMEOUT_EN
  assign bus.err_o        = r_err;
  assign bus.err_master_o = r_err_master;
`else
  assign bus.err_o        = 1'b0;
  assign bus.err_master_o = 2'd0;
`endif

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));

  a_cfg_range: assert property (@(posedge clk)
    (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 15) &&
    (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 65535));

endmodule

// File: tb/tb_rib_arbiter.sv
// Randomized + directed bench for rib_arbiter against a behavioural ownership model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rib_arbiter;

  localparam int LIMIT = 4;
  localparam int TO    = 8;

  logic clk;
  logic rst;

  rib_arbiter_if bus();

  rib_arbiter #(
    .STARVE_LIMIT   (LIMIT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: owner index (-1 = bus free), age per master, ack wait, error report.
  int         m_owner;
  int         m_age [3];
  int         m_wait;
  logic       m_err;
  logic [1:0] m_errm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_grant();
    logic [2:0] g;
    g = 3'b000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic exp_hold();
    logic [2:0] g;
    g = exp_grant();
    return bus.req_i[0] | bus.req_i[2] | g[0] | g[2];
  endfunction

  function automatic int pick(input logic [2:0] rq);
    int order [3];
    order = '{2, 0, 1};
    for (int i = 0; i < 3; i++) if (rq[i] && m_age[i] == LIMIT) return i;
    for (int k = 0; k < 3; k++) if (rq[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic mdl_tick();
    logic [2:0] rq;
    bit         arb;
    int         w;
    rq  = bus.req_i;
    arb = 0;
    if (rst) begin
      m_owner = -1;
      m_wait  = 0;
      m_err   = 1'b0;
      m_errm  = 2'd0;
      for (int i = 0; i < 3; i++) m_age[i] = 0;
      return;
    end
    m_err = 1'b0;
    if (m_owner < 0) begin
      arb = (rq != 3'b000);
    end else if (bus.ack_i) begin
      arb = 1;
    end else if (!rq[m_owner]) begin
      m_owner = -1;
    end else begin
`ifdef RIB_ARB_TIMEOUT_EN
      if (m_wait == TO) begin
        m_err          = 1'b1;
        m_errm         = 2'(m_owner);
        m_age[m_owner] = 0;
        m_owner        = -1;
      end else begin
        m_wait++;
      end
`endif
    end
    if (arb) begin
      w = pick(rq);
      for (int i = 0; i < 3; i++) begin
        if (i == w || !rq[i]) m_age[i] = 0;
        else if (m_age[i] < LIMIT) m_age[i]++;
      end
      m_owner = w;
      m_wait  = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    mdl_tick();
    #1;
    chk("grant", 32'(bus.grant_o), 32'(exp_grant()));
    chk("busy", 32'(bus.busy_o), 32'(m_owner >= 0));
    chk("err", 32'(bus.err_o), 32'(m_err));
    chk("err_master", 32'(bus.err_master_o), 32'(m_errm));
    chk("hold", 32'(bus.hold_flag_o), 32'(exp_hold()));
  endtask

  task automatic set_in(input logic [2:0] rq, input logic ak);
    bus.req_i = rq;
    bus.ack_i = ak;
    #1;
    chk("hold_comb", 32'(bus.hold_flag_o), 32'(exp_hold()));
  endtask

  initial begin
    logic [2:0] nrq;
    logic [2:0] seq_req [5];
    logic [2:0] seq_gnt [5];

    bus.req_i = 3'b000;
    bus.ack_i = 1'b0;
    rst       = 1'b1;
    m_owner   = -1;
    m_wait    = 0;
    m_err     = 1'b0;
    m_errm    = 2'd0;
    for (int i = 0; i < 3; i++) m_age[i] = 0;

    cyc();
    cyc();
    chk("rst_grant", 32'(bus.grant_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    rst = 1'b0;
    cyc();

    // Single request, ack and drop together.
    set_in(3'b001, 1'b0); cyc();
    chk("single_grant", 32'(bus.grant_o), 32'd1);
    cyc(); cyc();
    set_in(3'b000, 1'b1); cyc();
    chk("single_release", 32'(bus.grant_o), 32'd0);
    set_in(3'b000, 1'b0); cyc();

    // Priority m2 > m0 > m1.
    set_in(3'b111, 1'b0); cyc();
    chk("prio_m2", 32'(bus.grant_o), 32'b100);
    chk("prio_hold", 32'(bus.hold_flag_o), 32'd1);
    set_in(3'b011, 1'b1); cyc();
    chk("prio_m0", 32'(bus.grant_o), 32'b001);
    set_in(3'b010, 1'b1); cyc();
    chk("prio_m1", 32'(bus.grant_o), 32'b010);
    set_in(3'b000, 1'b1); cyc();
    set_in(3'b000, 1'b0); cyc();

    // Starvation: m1 wins on the fifth arbitration edge, then loses again.
    seq_req = '{3'b110, 3'b011, 3'b110, 3'b011, 3'b110};
    seq_gnt = '{3'b100, 3'b001, 3'b100, 3'b001, 3'b010};
    for (int k = 0; k < 5; k++) begin
      set_in(seq_req[k], (k != 0)); cyc();
      chk("starve_seq", 32'(bus.grant_o), 32'(seq_gnt[k]));
    end
    set_in(3'b110, 1'b1); cyc();
    chk("starve_cleared", 32'(bus.grant_o), 32'b100);
    set_in(3'b000, 1'b1); cyc();
    set_in(3'b000, 1'b0); cyc();

    // Abort: owner drops req without ack.
    set_in(3'b001, 1'b0); cyc(); cyc();
    set_in(3'b000, 1'b0); cyc();
    chk("abort_grant", 32'(bus.grant_o), 32'd0);
    chk("abort_err", 32'(bus.err_o), 32'd0);

`ifdef RIB_ARB_TIMEOUT_EN
    set_in(3'b100, 1'b0); cyc();
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k < 9) chk("to_wait_err", 32'(bus.err_o), 32'd0);
    end
    chk("to_err", 32'(bus.err_o), 32'd1);
    chk("to_master", 32'(bus.err_master_o), 32'd2);
    chk("to_grant", 32'(bus.grant_o), 32'd0);
    set_in(3'b000, 1'b0); cyc();
    chk("to_pulse_end", 32'(bus.err_o), 32'd0);
`else
    set_in(3'b100, 1'b0); cyc();
    repeat (1000) cyc();
    chk("no_to_hold", 32'(bus.grant_o), 32'b100);
    set_in(3'b000, 1'b1); cyc();
    set_in(3'b000, 1'b0); cyc();
`endif

    // Reset in the middle of a transaction.
    set_in(3'b010, 1'b0); cyc();
    chk("rst_mid_pre", 32'(bus.grant_o), 32'b010);
    rst = 1'b1; cyc();
    chk("rst_mid_grant", 32'(bus.grant_o), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_mid_err", 32'(bus.err_o), 32'd0);
    rst = 1'b0; cyc();
    chk("rst_mid_regrant", 32'(bus.grant_o), 32'b010);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      nrq = bus.req_i;
      for (int i = 0; i < 3; i++) begin
        if (m_owner == i) begin
          if ($urandom_range(15) == 0) nrq[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          nrq[i] = ~nrq[i];
        end
      end
      rst = ($urandom_range(199) == 0);
      set_in(nrq, ($urandom_range(3) == 0));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
